// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Summary  : Shares one backing RAM port between the instruction-cache and
//            data-cache refill/write paths. Grants one side at a time, holds
//            the RAM address/enables for RAM_LAT cycles, captures the read
//            word and pulses the winner's ack for one cycle.
// Options  : ARB_ROUND_ROBIN_EN - alternate ties between the two sides;
//            when undefined the data side always wins ties.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int A_WIDTH = 8,
    parameter int D_WIDTH = 16,
    parameter int RAM_LAT = 2
) (
    input  logic               g_clk,
    input  logic               g_clr,
    input  logic               i_req,
    input  logic               i_we,
    input  logic [A_WIDTH-1:0] i_addr,
    input  logic [D_WIDTH-1:0] i_wdata,
    output logic               i_ack,
    input  logic               d_req,
    input  logic               d_we,
    input  logic [A_WIDTH-1:0] d_addr,
    input  logic [D_WIDTH-1:0] d_wdata,
    output logic               d_ack,
    output logic [D_WIDTH-1:0] rdata,
    output logic [A_WIDTH-1:0] ram_addr,
    output logic               ram_re,
    output logic               ram_we,
    output logic [D_WIDTH-1:0] ram_wdata,
    input  logic [D_WIDTH-1:0] ram_rdata,
    output logic               busy,
    output logic               grant_d
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_ACCESS = 2'd1;
    localparam logic [1:0] c_ACK    = 2'd2;

    // Counter is loaded with the number of remaining access cycles after
    // the first one; RAM_LAT up to 15 fits in four bits.
    localparam logic [3:0] c_LAT_M1 = 4'(RAM_LAT - 1);

    logic [1:0] r_state;
    logic [3:0] r_cnt;
    logic       r_we;      // latched direction of the access in progress

    logic       w_prio_d;  // data side wins a tie
    logic       w_any_req;
    logic       w_pick_d;

    // Tie resolution; grant_d doubles as the last-grant register.
    always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
        w_prio_d = ~grant_d;
`else
        w_prio_d = 1'b1;
`endif
        w_any_req = i_req | d_req;
        w_pick_d  = d_req & (~i_req | w_prio_d);
    end

    // Request sequencer: IDLE grants, ACCESS drives the RAM, ACK pulses.
    always_ff @(posedge g_clk) begin
        if (g_clr) begin
            r_state   <= c_IDLE;
            r_cnt     <= 4'd0;
            r_we      <= 1'b0;
            i_ack     <= 1'b0;
            d_ack     <= 1'b0;
            rdata     <= '0;
            ram_addr  <= '0;
            ram_re    <= 1'b0;
            ram_we    <= 1'b0;
            ram_wdata <= '0;
            busy      <= 1'b0;
            grant_d   <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    i_ack <= 1'b0;
                    d_ack <= 1'b0;
                    if (w_any_req) begin
                        // The RAM-facing registers are the latched request,
                        // so later changes on the requester pins are ignored.
                        grant_d   <= w_pick_d;
                        ram_addr  <= w_pick_d ? d_addr  : i_addr;
                        ram_wdata <= w_pick_d ? d_wdata : i_wdata;
                        r_we      <= w_pick_d ? d_we    : i_we;
                        ram_re    <= w_pick_d ? ~d_we   : ~i_we;
                        ram_we    <= w_pick_d ? d_we    : i_we;
                        r_cnt     <= c_LAT_M1;
                        busy      <= 1'b1;
                        r_state   <= c_ACCESS;
                    end
                end
                c_ACCESS: begin
                    // Write strobe lives only in the first access cycle.
                    ram_we <= 1'b0;
                    if (r_cnt == 4'd0) begin
                        if (!r_we) begin
                            rdata <= ram_rdata;
                        end
                        ram_re <= 1'b0;
                        if (grant_d) begin
                            d_ack <= 1'b1;
                        end else begin
                            i_ack <= 1'b1;
                        end
                        r_state <= c_ACK;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                c_ACK: begin
                    i_ack   <= 1'b0;
                    d_ack   <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= c_IDLE;
                end
                default: begin
                    i_ack   <= 1'b0;
                    d_ack   <= 1'b0;
                    ram_re  <= 1'b0;
                    ram_we  <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Summary  : Directed self-checking bench for mem_port_arbiter (default
//            latency instance plus a RAM_LAT=4 instance sharing one RAM).
//            Tie expectations follow ARB_ROUND_ROBIN_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        g_clr;

    logic        i_req, i_we, d_req, d_we;
    logic [7:0]  i_addr, d_addr;
    logic [15:0] i_wdata, d_wdata;
    logic        i_ack, d_ack, busy, grant_d;
    logic [15:0] rdata;
    logic [7:0]  ram_addr;
    logic        ram_re, ram_we;
    logic [15:0] ram_wdata, ram_rdata;

    logic        i2_req;
    logic [7:0]  i2_addr;
    logic        tie0;
    logic [7:0]  tie_addr;
    logic [15:0] tie_data;
    logic        i2_ack, d2_ack, busy2, grant_d2;
    logic [15:0] rdata2;
    logic [7:0]  ram_addr2;
    logic        ram_re2, ram_we2;
    logic [15:0] ram_wdata2, ram_rdata2;

    logic [15:0] mem [256];
    logic        tb_load;
    logic [7:0]  tb_addr;
    logic [15:0] tb_data;
    int          wr_count = 0;

    int checks = 0;
    int errors = 0;

    logic [11:0] exp_d_v, exp_i_v;
    int          wr_base;

    always #5 clk = ~clk;

    mem_port_arbiter #(.A_WIDTH(8), .D_WIDTH(16), .RAM_LAT(2)) u_dut (
        .g_clk(clk), .g_clr(g_clr),
        .i_req(i_req), .i_we(i_we), .i_addr(i_addr), .i_wdata(i_wdata), .i_ack(i_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack),
        .rdata(rdata), .ram_addr(ram_addr), .ram_re(ram_re), .ram_we(ram_we),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .busy(busy), .grant_d(grant_d)
    );

    mem_port_arbiter #(.A_WIDTH(8), .D_WIDTH(16), .RAM_LAT(4)) u_lat4 (
        .g_clk(clk), .g_clr(g_clr),
        .i_req(i2_req), .i_we(tie0), .i_addr(i2_addr), .i_wdata(tie_data), .i_ack(i2_ack),
        .d_req(tie0), .d_we(tie0), .d_addr(tie_addr), .d_wdata(tie_data), .d_ack(d2_ack),
        .rdata(rdata2), .ram_addr(ram_addr2), .ram_re(ram_re2), .ram_we(ram_we2),
        .ram_wdata(ram_wdata2), .ram_rdata(ram_rdata2), .busy(busy2), .grant_d(grant_d2)
    );

    assign ram_rdata  = mem[ram_addr];
    assign ram_rdata2 = mem[ram_addr2];

    // Shared RAM: DUT writes, bench preloads, every DUT write strobe counted.
    always @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
            wr_count      <= wr_count + 1;
        end else if (tb_load) begin
            mem[tb_addr] <= tb_data;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic load(input logic [7:0] a, input logic [15:0] v);
        tb_load = 1'b1; tb_addr = a; tb_data = v;
        cyc();
        tb_load = 1'b0;
    endtask

    initial begin
        g_clr = 1'b1; tb_load = 1'b0; tb_addr = '0; tb_data = '0;
        i_req = 0; i_we = 0; i_addr = '0; i_wdata = '0;
        d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
        i2_req = 0; i2_addr = '0; tie0 = 0; tie_addr = '0; tie_data = '0;

        // Preload RAM while in reset
        cyc();
        load(8'h10, 16'hBEEF);
        load(8'h20, 16'h1234);
        load(8'h55, 16'hDEAD);
        load(8'h3C, 16'h0000);

        // Reset values
        check("rst_i_ack", i_ack, 0);
        check("rst_d_ack", d_ack, 0);
        check("rst_rdata", rdata, 0);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_ram_re", ram_re, 0);
        check("rst_ram_we", ram_we, 0);
        check("rst_ram_wdata", ram_wdata, 0);
        check("rst_busy", busy, 0);
        check("rst_grant_d", grant_d, 0);
        g_clr = 1'b0;
        cyc();

        // Single I read of 0x10: re in cycles 1-2, ack in cycle 3
        i_req = 1; i_we = 0; i_addr = 8'h10;
        cyc();
        check("ird_c1_re", ram_re, 1);
        check("ird_c1_addr", ram_addr, 8'h10);
        check("ird_c1_busy", busy, 1);
        check("ird_c1_ack", i_ack, 0);
        cyc();
        check("ird_c2_re", ram_re, 1);
        check("ird_c2_ack", i_ack, 0);
        cyc();
        check("ird_c3_ack", i_ack, 1);
        check("ird_c3_rdata", rdata, 16'hBEEF);
        check("ird_c3_dack", d_ack, 0);
        check("ird_c3_re", ram_re, 0);
        check("ird_c3_gnt", grant_d, 0);
        i_req = 0;
        cyc();
        check("ird_c4_ack", i_ack, 0);
        check("ird_c4_busy", busy, 0);

        // Single D write 0x00A5 -> 0x3C: one write strobe, rdata unchanged
        wr_base = wr_count;
        d_req = 1; d_we = 1; d_addr = 8'h3C; d_wdata = 16'h00A5;
        cyc();
        check("dwr_c1_we", ram_we, 1);
        check("dwr_c1_re", ram_re, 0);
        check("dwr_c1_wdata", ram_wdata, 16'h00A5);
        cyc();
        check("dwr_c2_we", ram_we, 0);
        check("dwr_c2_ack", d_ack, 0);
        cyc();
        check("dwr_c3_ack", d_ack, 1);
        check("dwr_c3_iack", i_ack, 0);
        check("dwr_c3_rdata", rdata, 16'hBEEF);
        check("dwr_mem", mem[8'h3C], 16'h00A5);
        check("dwr_count", wr_count - wr_base, 1);
        check("dwr_gnt", grant_d, 1);
        d_req = 0;
        cyc();

        // Tie from reset: both sides reading, requests held continuously
        g_clr = 1;
        cyc();
        g_clr = 0;
        d_we = 0; d_addr = 8'h3C; i_we = 0; i_addr = 8'h10;
`ifdef ARB_ROUND_ROBIN_EN
        exp_d_v = 12'b1000_0000_1000;
        exp_i_v = 12'b0000_1000_0000;
`else
        exp_d_v = 12'b1000_1000_1000;
        exp_i_v = 12'b0000_0000_0000;
`endif
        i_req = 1; d_req = 1;
        for (int k = 1; k <= 11; k++) begin
            cyc();
            check($sformatf("tie_dack_c%0d", k), d_ack, exp_d_v[k]);
            check($sformatf("tie_iack_c%0d", k), i_ack, exp_i_v[k]);
        end
        check("tie_rdata", rdata, 16'h00A5);
        check("tie_gnt", grant_d, 1);
        i_req = 0; d_req = 0;
        cyc();
        check("tie_idle", busy, 0);

        // Reset in cycle 2 of a D write: access abandoned
        d_req = 1; d_we = 1; d_addr = 8'h3C; d_wdata = 16'h7777;
        cyc();
        check("rma_c1_we", ram_we, 1);
        cyc();
        g_clr = 1; d_req = 0;
        cyc();
        check("rma_busy", busy, 0);
        check("rma_we", ram_we, 0);
        check("rma_re", ram_re, 0);
        check("rma_dack", d_ack, 0);
        check("rma_rdata", rdata, 0);
        g_clr = 0;
        cyc();
        check("rma_c4_dack", d_ack, 0);
        check("rma_c4_busy", busy, 0);

        // New I read after the abort completes in 3 cycles
        i_req = 1; i_we = 0; i_addr = 8'h10;
        cyc();
        check("post_c1_re", ram_re, 1);
        cyc();
        check("post_c2_ack", i_ack, 0);
        cyc();
        check("post_c3_ack", i_ack, 1);
        check("post_c3_rdata", rdata, 16'hBEEF);
        i_req = 0;
        cyc();

        // RAM_LAT=4 instance: re in cycles 1-4, ack in 5, addr latched
        i2_req = 1; i2_addr = 8'h20;
        for (int k = 1; k <= 4; k++) begin
            cyc();
            if (k == 2) i2_addr = 8'h55;
            check($sformatf("lat4_re_c%0d", k), ram_re2, 1);
            check($sformatf("lat4_addr_c%0d", k), ram_addr2, 8'h20);
            check($sformatf("lat4_ack_c%0d", k), i2_ack, 0);
        end
        cyc();
        check("lat4_c5_ack", i2_ack, 1);
        check("lat4_c5_rdata", rdata2, 16'h1234);
        check("lat4_c5_re", ram_re2, 0);
        check("lat4_c5_dack", d2_ack, 0);
        i2_req = 0;
        cyc();
        check("lat4_c6_ack", i2_ack, 0);
        check("lat4_c6_busy", busy2, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
